addsub_serial: RTL and testbench

//  Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_digit.sv | 23 ++
 rtl/addsub_serial.sv | 122 ++++++++++++
 tb/tb_addsub_serial.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; reports carry out and carry into the slice MSB.
module addsub_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    always_comb begin
        full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        sum   = full[DIGIT-1:0];
        cout  = full[DIGIT];
        // Carry into the MSB recovered from the MSB sum bit: s = x ^ y ^ cin_msb.
        c_msb = x[DIGIT-1] ^ y[DIGIT-1] ^ full[DIGIT-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes
// and carry / signed-overflow / zero flags.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("addsub_serial: WIDTH must be a nonzero multiple of DIGIT");
        end
    endgenerate

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       wa, wb, wr, wr_nxt;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   accept, last;
    logic [DIGIT-1:0]       dsum;
    logic                   dcout, dcmsb;
    logic [WIDTH+DIGIT-1:0] cat;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (wa[DIGIT-1:0]),
        .y     (wb[DIGIT-1:0]),
        .cin   (carry),
        .sum   (dsum),
        .cout  (dcout),
        .c_msb (dcmsb)
    );

    always_comb begin
        accept = in_valid && in_ready;
        last   = (cnt == CW'(NDIG - 1));
        // New digit enters at the MSB end; the concatenation also covers DIGIT == WIDTH.
        cat    = {dsum, wr};
        wr_nxt = cat[WIDTH+DIGIT-1:DIGIT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa    <= '0;
            wb    <= '0;
            wr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wa    <= a;
                        wb    <= b ^ {WIDTH{m}};
                        carry <= (m == OP_SUB);
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    wa    <= wa >> DIGIT;
                    wb    <= wb >> DIGIT;
                    wr    <= wr_nxt;
                    carry <= dcout;
                    cnt   <= cnt + CW'(1);
                    // Flags load on the same edge that enters DONE.
                    if (last) begin
                        s <= wr_nxt;
                        c <= dcout;
                        v <= dcout ^ dcmsb;
                        z <= (wr_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Randomized self-checking bench for addsub_serial against an integer arithmetic model.
module tb_addsub_serial;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, m, out_valid, out_ready, c, v, z;
    logic [W-1:0] a, b, s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c),
        .v         (v),
        .z         (z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                                  output logic [7:0] es, output logic ec, output logic ev,
                                  output logic ez);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(ta);
        ub = int'(tb);
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        ur = tm ? ua - ub : ua + ub;
        sr = tm ? sa - sb : sa + sb;
        es = 8'(ur);
        ec = tm ? (ua >= ub) : (ur > 255);
        ev = (sr > 127) || (sr < -128);
        ez = (es == 8'h00);
    endfunction

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                                input logic tm);
        logic [7:0] es;
        logic       ec, ev, ez;
        model(ta, tb, tm, es, ec, ev, ez);
        check({tag, "_s"}, s, es);
        check({tag, "_c"}, c, ec);
        check({tag, "_v"}, v, ev);
        check({tag, "_z"}, z, ez);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tm, input int stall);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        a = ta; b = tb; m = tm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); m = 1'($urandom);
        check({tag, "_busy"}, in_ready, 0);
        wait_out(n);
        check({tag, "_lat"}, n, NDIG);
        check_result(tag, ta, tb, tm);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, out_valid, 1);
        end
        check_result({tag, "_held"}, ta, tb, tm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovdrop"}, out_valid, 0);
        check({tag, "_rdyback"}, in_ready, 1);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; m = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cvz", {c, v, z}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("t1", 8'd100, 8'd27, 1'b0, 0);
        check("t1_abs", s, 8'd127);
        run_op("t2a", 8'd100, 8'd28, 1'b0, 1);
        check("t2a_abs", {s, c, v, z}, {8'h80, 3'b010});
        run_op("t2b", 8'hFF, 8'h01, 1'b0, 0);
        check("t2b_abs", {s, c, v, z}, {8'h00, 3'b101});
        run_op("t3a", 8'd5, 8'd5, 1'b1, 2);
        check("t3a_abs", {s, c, v, z}, {8'h00, 3'b101});
        run_op("t3b", 8'd3, 8'd5, 1'b1, 0);
        check("t3b_abs", {s, c, v, z}, {8'hFE, 3'b000});
        run_op("t3c", 8'h80, 8'h01, 1'b1, 0);
        check("t3c_abs", {s, c, v, z}, {8'h7F, 3'b110});

        // Backpressure with a new operand pending.
        a = 8'd100; b = 8'd27; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        check("bp_lat", n, NDIG);
        a = 8'h80; b = 8'h01; m = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_flags", {s, c, v, z}, {8'd127, 3'b000});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_ovdrop", out_valid, 0);
        check("bp_rdyback", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        wait_out(n);
        check("bp2_lat", n, NDIG);
        check_result("bp2", 8'h80, 8'h01, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        a = 8'd9; b = 8'd4; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_pre_s", s, 8'h7F);
        rst = 1'b1;
        #1;
        check("mid_rst_s", s, 0);
        check("mid_rst_cvz", {c, v, z}, 0);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_rdy", in_ready, 1);
        #3 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_no_ov", out_valid, 0);
        end
        check("mid_rdy", in_ready, 1);

        for (int i = 0; i < 1200; i++) begin
            run_op("rnd", pick(), pick(), 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
